// File: rtl/nes_pkg.sv
// Shared state encoding, button indices and bundles for the NES pad poller.
package nes_pkg;

  typedef enum logic [2:0] {
    IDLE_ST,
    LATCH_ST,
    PULSE_HI_ST,
    PULSE_LO_ST,
    DONE_ST
  } nes_state_t;

  localparam int NES_BITS = 8;

  localparam logic [2:0] BTN_A      = 3'd0;
  localparam logic [2:0] BTN_B      = 3'd1;
  localparam logic [2:0] BTN_SELECT = 3'd2;
  localparam logic [2:0] BTN_START  = 3'd3;
  localparam logic [2:0] BTN_UP     = 3'd4;
  localparam logic [2:0] BTN_DOWN   = 3'd5;
  localparam logic [2:0] BTN_LEFT   = 3'd6;
  localparam logic [2:0] BTN_RIGHT  = 3'd7;

  typedef struct packed {
    logic b;
    logic a;
  } ab_t;

endpackage

// File: rtl/nes_step_gen.sv
// Turns A/B of each decoded frame into a count direction and a one-cycle step.
// NES_AUTOREPEAT_EN adds a held-button auto-repeat every REPEAT_FRAMES frames.
module nes_step_gen
  import nes_pkg::*;
#(
  parameter int REPEAT_FRAMES = 8
) (
  input  logic clock,
  input  logic resetN,
  input  logic frame_valid,
  input  ab_t  ab,
  output logic ud,
  output logic count_step
);

  if (REPEAT_FRAMES < 1) begin : g_bad_repeat
    $error("REPEAT_FRAMES must be >= 1");
  end

  logic step_req;
  logic ud_q, ud_d;
  logic step_q, step_d;
  logic prev_q, prev_d;

  assign step_req = ab.a ^ ab.b;

`ifdef NES_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_FRAMES + 1);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_FRAMES - 1);

  logic [RW-1:0] rep_q, rep_d;

  always_comb begin
    ud_d   = ud_q;
    step_d = 1'b0;
    prev_d = prev_q;
    rep_d  = rep_q;
    if (frame_valid) begin
      ud_d   = ab.a & ~ab.b;
      prev_d = step_req;
      if (!step_req) begin
        rep_d = '0;
      end else if (!prev_q) begin
        step_d = 1'b1;
        rep_d  = '0;
      end else if (rep_q == REP_LAST) begin
        step_d = 1'b1;
        rep_d  = '0;
      end else begin
        rep_d = rep_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!resetN) rep_q <= '0;
    else         rep_q <= rep_d;
  end
`else
  always_comb begin
    ud_d   = ud_q;
    step_d = 1'b0;
    prev_d = prev_q;
    if (frame_valid) begin
      ud_d   = ab.a & ~ab.b;
      prev_d = step_req;
      step_d = step_req & ~prev_q;
    end
  end
`endif

  always_ff @(posedge clock) begin
    if (!resetN) begin
      ud_q   <= 1'b0;
      step_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      ud_q   <= ud_d;
      step_q <= step_d;
      prev_q <= prev_d;
    end
  end

  assign ud         = ud_q;
  assign count_step = step_q;

endmodule

// File: rtl/nes_pad_sequencer.sv
// NES controller poller: latch/pulse sequencing, serial capture, frame publish.
// Optional NES_AUTOREPEAT_EN enables auto-repeat steps in nes_step_gen.
module nes_pad_sequencer
  import nes_pkg::*;
#(
  parameter int LATCH_CYCLES  = 12,
  parameter int HALF_CYCLES   = 6,
  parameter int POLL_CYCLES   = 1000,
  parameter int REPEAT_FRAMES = 8
) (
  input  logic                clock,
  input  logic                resetN,
  input  logic                nesData,
  output logic                nesLatch,
  output logic                nesPulse,
  output logic [NES_BITS-1:0] buttons,
  output logic                frameValid,
  output logic                ud,
  output logic                countStep
);

  localparam int PMAX =
    (LATCH_CYCLES > HALF_CYCLES) ? LATCH_CYCLES : HALF_CYCLES;
  localparam int PW = $clog2(PMAX);
  localparam int CW = $clog2(POLL_CYCLES);

  localparam logic [PW-1:0] LATCH_LAST = PW'(LATCH_CYCLES - 1);
  localparam logic [PW-1:0] HALF_LAST  = PW'(HALF_CYCLES - 1);
  localparam logic [CW-1:0] POLL_LAST  = CW'(POLL_CYCLES - 1);

  nes_state_t          state_q, state_d;
  logic [PW-1:0]       phase_q, phase_d;
  logic [CW-1:0]       poll_q, poll_d;
  logic [2:0]          bit_q, bit_d;
  logic [NES_BITS-1:0] shift_q, shift_d;
  logic [NES_BITS-1:0] btn_q, btn_d;
  logic                fv_q, fv_d;
  logic                phase_end;
  ab_t                 ab;

  assign phase_end = (state_q == LATCH_ST) ? (phase_q == LATCH_LAST)
                                           : (phase_q == HALF_LAST);

  always_ff @(posedge clock) begin
    if (!resetN) state_q <= LATCH_ST;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      LATCH_ST:    if (phase_end) state_d = PULSE_HI_ST;
      PULSE_HI_ST: if (phase_end) state_d = PULSE_LO_ST;
      PULSE_LO_ST: if (phase_end)
                     state_d = (bit_q == 3'd6) ? DONE_ST : PULSE_HI_ST;
      DONE_ST:     state_d = IDLE_ST;
      IDLE_ST:     if (poll_q == POLL_LAST) state_d = LATCH_ST;
      default:     state_d = LATCH_ST;
    endcase
  end

  // The controller latch is held off while reset is asserted so the pad
  // never sees a latch during reset, yet rises as soon as reset lifts.
  always_comb begin
    nesLatch = resetN && (state_q == LATCH_ST);
    nesPulse = (state_q == PULSE_HI_ST);
  end

  always_comb begin
    phase_d = phase_q + 1'b1;
    if (state_d != state_q || state_q == IDLE_ST) phase_d = '0;

    poll_d = poll_q;
    if (state_d == LATCH_ST && state_q != LATCH_ST) poll_d = '0;
    else if (poll_q != POLL_LAST)                   poll_d = poll_q + 1'b1;

    shift_d = shift_q;
    bit_d   = bit_q;
    if (phase_end && state_q == LATCH_ST) begin
      shift_d[0] = nesData;
      bit_d      = '0;
    end else if (phase_end && state_q == PULSE_LO_ST) begin
      shift_d[bit_q + 3'd1] = nesData;
      bit_d                 = bit_q + 3'd1;
    end

    btn_d = btn_q;
    fv_d  = (state_q == DONE_ST);
    if (state_q == DONE_ST) btn_d = ~shift_q;
  end

  always_ff @(posedge clock) begin
    if (!resetN) begin
      phase_q <= '0;
      poll_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      btn_q   <= '0;
      fv_q    <= 1'b0;
    end else begin
      phase_q <= phase_d;
      poll_q  <= poll_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      btn_q   <= btn_d;
      fv_q    <= fv_d;
    end
  end

  assign buttons    = btn_q;
  assign frameValid = fv_q;
  assign ab         = '{a: btn_q[BTN_A], b: btn_q[BTN_B]};

  nes_step_gen #(
    .REPEAT_FRAMES(REPEAT_FRAMES)
  ) u_step (
    .clock      (clock),
    .resetN     (resetN),
    .frame_valid(fv_q),
    .ab         (ab),
    .ud         (ud),
    .count_step (countStep)
  );

endmodule
